contador_updown_param: RTL
==========================

Name: contador_updown_param

Overview:
- Parametrised successor to the team's 8-bit up/down counter.
- Adds configurable width and modulus, selectable wrap or saturate mode, count enable, synchronous clear, and parallel load.
- Adds terminal-count, wrap and saturation status outputs.
- Used as the generic event/position counter in the team's datapath blocks; one instance per counted quantity.

Parameters:
- WIDTH, 8, counter width in bits (2..32).
- MAX_VAL, 2**WIDTH-1, highest legal count; range is 0..MAX_VAL; must satisfy 1 <= MAX_VAL <= 2**WIDTH-1.
- SAT_MODE, 0, 0 = wrap at the bounds (modulo MAX_VAL+1); 1 = saturate at the bounds.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  asynchronous reset, active-low.
- clear  input  1  synchronous clear of count and sticky flag.
- load  input  1  synchronous parallel load.
- load_val  input  WIDTH  value to load.
- en  input  1  count enable.
- up_down  input  1  1 = count up, 0 = count down.
- cuenta  output  WIDTH  current count, registered.
- at_max  output  1  combinational; cuenta == MAX_VAL.
- at_min  output  1  combinational; cuenta == 0.
- wrap_pulse  output  1  registered; high for one cycle after a wrap step.
- sat_flag  output  1  registered, sticky; set when a step is blocked at a bound (SAT_MODE=1 only).

Behaviour:
- Reset: rst low asynchronously forces cuenta=0, wrap_pulse=0, sat_flag=0 (so at_min=1, at_max=0). Held while rst is low. Release is synchronous to the next clk edge; the first update occurs on the first rising edge with rst high.
- Priority per edge: clear > load > en. up_down is ignored unless en=1 and no higher-priority operation applies.
- clear=1: cuenta<=0, sat_flag<=0, wrap_pulse<=0.
- load=1 (clear=0): cuenta<=load_val if load_val<=MAX_VAL, else MAX_VAL (clamped). wrap_pulse<=0; sat_flag unchanged.
- en=1, up_down=1:
  - cuenta<MAX_VAL: cuenta+1.
  - cuenta==MAX_VAL, SAT_MODE=0: cuenta<=0, wrap_pulse<=1.
  - cuenta==MAX_VAL, SAT_MODE=1: cuenta holds, sat_flag<=1.
- en=1, up_down=0:
  - cuenta>0: cuenta-1.
  - cuenta==0, SAT_MODE=0: cuenta<=MAX_VAL, wrap_pulse<=1.
  - cuenta==0, SAT_MODE=1: cuenta holds, sat_flag<=1.
- en=0 (no clear/load): cuenta holds, wrap_pulse<=0, sat_flag holds.
- wrap_pulse is deasserted on every edge that does not wrap; back-to-back wraps (e.g. MAX_VAL=1, en held) keep it high on consecutive cycles.
- sat_flag is cleared only by rst or clear; it is never set when SAT_MODE=0.
- Arithmetic:
  - internal compare at WIDTH bits; no intermediate overflow beyond WIDTH.
  - when MAX_VAL=2**WIDTH-1, wrap mode equals natural modulo-2**WIDTH behaviour, identical to the legacy 8-bit counter (apart from reset polarity and enable).
- Reset mid-operation: rst assertion overrides any in-flight clear/load/en immediately, without waiting for clk.
- Status outputs at_max/at_min follow cuenta combinationally, with no added latency. Both are high only when MAX_VAL=0, which is illegal.
- Latency: one clk edge from input to cuenta update; wrap_pulse and sat_flag update on the same edge as the triggering step.

Test Plan:
- WIDTH=8, MAX_VAL=255, SAT_MODE=0: reset, en=1, up_down=1 for 256 cycles -> cuenta 0,1,...,255,0; wrap_pulse high exactly on the cycle cuenta returns to 0.
- WIDTH=4, MAX_VAL=9, SAT_MODE=0: from 0, count down 1 step -> cuenta=9, wrap_pulse=1. Count up 10 steps -> back to 9, with one wrap at 9->0.
- WIDTH=4, MAX_VAL=9, SAT_MODE=1: load 8, count up 3 cycles -> cuenta 9,9,9; at_max=1; sat_flag=1 from the second step. Then clear -> cuenta=0, sat_flag=0.
- Priority: clear=1, load=1, load_val=5, en=1 same edge -> cuenta=0. Next edge load=1, en=1, up_down=1, load_val=5 -> cuenta=5. load_val=12 with MAX_VAL=9 -> cuenta=9.
- Async reset: cuenta=7 mid-count, drop rst between clock edges -> cuenta=0 and flags 0 before the next edge. Hold rst low for 3 edges -> stays 0. Release with en=1, up_down=1 -> 1 after the first edge.
- en=0 for 5 cycles with up_down toggling -> cuenta constant, wrap_pulse=0, sat_flag unchanged.

Source files
------------

// File: rtl/contador_updown_param.sv
// -----------------------------------------------------------------------------
// contador_updown_param
// Generic up/down event/position counter with configurable width and modulus.
// Counts over 0..MAX_VAL, either wrapping (modulo MAX_VAL+1) or saturating at
// the bounds. Supports synchronous clear, parallel load (clamped to MAX_VAL)
// and count enable, with priority clear > load > en.
//
// Parameters:
//   WIDTH    counter width in bits (2..32)
//   MAX_VAL  highest legal count, 1 <= MAX_VAL <= 2**WIDTH-1
//   SAT_MODE 0 = wrap at the bounds, 1 = saturate at the bounds
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous reset, active-low
//   clear      in   synchronous clear of count, wrap pulse and sticky flag
//   load       in   synchronous parallel load of load_val
//   load_val   in   [WIDTH] value to load (clamped to MAX_VAL)
//   en         in   count enable
//   up_down    in   1 = count up, 0 = count down
//   cuenta     out  [WIDTH] current count (registered)
//   at_max     out  cuenta == MAX_VAL (combinational from the register)
//   at_min     out  cuenta == 0 (combinational from the register)
//   wrap_pulse out  one-cycle pulse after a wrap step (registered)
//   sat_flag   out  sticky, set when a step is blocked at a bound (registered)
// -----------------------------------------------------------------------------
module contador_updown_param #(
  parameter int                WIDTH    = 8,
  parameter logic [WIDTH-1:0]  MAX_VAL  = {WIDTH{1'b1}},
  parameter bit                SAT_MODE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up_down,
  output logic [WIDTH-1:0] cuenta,
  output logic             at_max,
  output logic             at_min,
  output logic             wrap_pulse,
  output logic             sat_flag
);

  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] cuenta_r;
  logic             wrap_r;
  logic             sat_r;

  logic [WIDTH-1:0] cuenta_next_s;
  logic             wrap_next_s;
  logic             sat_next_s;
  logic             top_s;
  logic             bottom_s;

  // Bound detection on the current count, shared by stepping and status outputs.
  always_comb begin
    top_s    = (cuenta_r == MAX_VAL);
    bottom_s = (cuenta_r == ZERO);
  end

  // Next-state selection: clear beats load beats counting. Bound checks are
  // equality compares at WIDTH bits, so +1/-1 are only taken strictly inside
  // the range and never overflow.
  always_comb begin
    cuenta_next_s = cuenta_r;
    wrap_next_s   = 1'b0;
    sat_next_s    = sat_r;
    if (clear) begin
      cuenta_next_s = ZERO;
      sat_next_s    = 1'b0;
    end else if (load) begin
      if (load_val > MAX_VAL) begin
        cuenta_next_s = MAX_VAL;
      end else begin
        cuenta_next_s = load_val;
      end
    end else if (en) begin
      case (up_down)
        1'b1: begin
          if (!top_s) begin
            cuenta_next_s = cuenta_r + ONE;
          end else if (SAT_MODE) begin
            sat_next_s = 1'b1;
          end else begin
            cuenta_next_s = ZERO;
            wrap_next_s   = 1'b1;
          end
        end
        1'b0: begin
          if (!bottom_s) begin
            cuenta_next_s = cuenta_r - ONE;
          end else if (SAT_MODE) begin
            sat_next_s = 1'b1;
          end else begin
            cuenta_next_s = MAX_VAL;
            wrap_next_s   = 1'b1;
          end
        end
        default: begin
          cuenta_next_s = cuenta_r;
          wrap_next_s   = 1'b0;
          sat_next_s    = sat_r;
        end
      endcase
    end else begin
      cuenta_next_s = cuenta_r;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cuenta_r <= ZERO;
      wrap_r   <= 1'b0;
      sat_r    <= 1'b0;
    end else begin
      cuenta_r <= cuenta_next_s;
      wrap_r   <= wrap_next_s;
      sat_r    <= sat_next_s;
    end
  end

  assign cuenta     = cuenta_r;
  assign wrap_pulse = wrap_r;
  assign sat_flag   = sat_r;
  assign at_max     = top_s;
  assign at_min     = bottom_s;

endmodule
